// File: rtl/mcycle_muldiv_if.sv
// Handshake and data bundle between the decoder/hazard logic and the multi-cycle mul/div unit.
// The master issues Start/MCycleOp/operands; the slave returns results with Busy/Done.
interface mcycle_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic             MCycleOp;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result1;
   logic [WIDTH-1:0] Result2;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, MCycleOp, Operand1, Operand2,
      input  Result1, Result2, Busy, Done
   );

   modport slave (
      input  Start, MCycleOp, Operand1, Operand2,
      output Result1, Result2, Busy, Done
   );
endinterface

// File: rtl/mcycle_muldiv.sv
// Iterative unsigned shift-add multiply / restoring divide, one bit per cycle, WIDTH+1 cycles Start to Done.
// Busy stalls the pipeline from the accept cycle through COMPUTING; Start is ignored outside IDLE.
module mcycle_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   mcycle_muldiv_if.slave    bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTING,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             op_q, op_d;
   // opnd_q holds the multiplicand for MUL and the divisor for DIV.
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res1_q, res1_d;
   logic [WIDTH-1:0] res2_q, res2_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   iter_hi;
   logic [WIDTH-1:0] iter_lo;

   // hi_q[WIDTH] is provably zero in both modes, so the sums below cannot overflow.
   always_comb begin
      mul_sum = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
      q_sh    = {lo_q[WIDTH-2:0], 1'b0};
      trial   = {1'b0, rem_sh} - {2'b00, opnd_q};
      iter_hi = rem_sh;
      iter_lo = q_sh;
      if (!op_q) begin
         iter_hi = {1'b0, mul_sum[WIDTH:1]};
         iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (!trial[WIDTH+1]) begin
         iter_hi = trial[WIDTH:0];
         iter_lo = {lo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res1_d  = res1_q;
      res2_d  = res2_q;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               state_d = S_COMPUTING;
               count_d = '0;
               op_d    = bus.MCycleOp;
               hi_d    = '0;
               if (bus.MCycleOp) begin
                  opnd_d = bus.Operand2;
                  lo_d   = bus.Operand1;
               end else begin
                  opnd_d = bus.Operand1;
                  lo_d   = bus.Operand2;
               end
            end
         end
         S_COMPUTING: begin
            hi_d = iter_hi;
            lo_d = iter_lo;
            if (count_q == CNT_W'(WIDTH - 1)) begin
               res1_d  = iter_lo;
               res2_d  = iter_hi[WIDTH-1:0];
               state_d = S_DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         count_q <= '0;
         op_q    <= 1'b0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res1_q  <= '0;
         res2_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res1_q  <= res1_d;
         res2_q  <= res2_d;
      end
   end

   assign bus.Busy    = ((state_q == S_IDLE) && bus.Start) || (state_q == S_COMPUTING);
   assign bus.Done    = (state_q == S_DONE);
   assign bus.Result1 = res1_q;
   assign bus.Result2 = res2_q;
endmodule
